// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Frame states, sync byte default and word geometry.
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Little-endian byte-to-word assembler for the loader.
// word/word_valid are valid in the cycle the last byte arrives.
module byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        valid,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] lo;

  assign word_valid = valid && (idx == 2'(WORD_BYTES - 1));
  assign word = {din, lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      lo  <= '0;
    end else if (clear) begin
      idx <= '0;
      lo  <= '0;
    end else if (valid) begin
      unique case (idx)
        2'd0:    lo[7:0]   <= din;
        2'd1:    lo[15:8]  <= din;
        2'd2:    lo[23:16] <= din;
        default: ;
      endcase
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Host byte-stream loader for the instruction memory.
// Keeps the CPU held until a checksum-verified image is written.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int         MEM_WORDS = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic             mem_we,
  output logic [31:0]      mem_waddr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] words_written
);

  localparam logic [7:0] MAX_N = 8'(MEM_WORDS);

  state_t           state;
  logic [IDX_W-1:0] n_words;
  logic [IDX_W-1:0] ww_next;
  logic [7:0]       csum;
  logic             take;
  logic             pk_clear;
  logic             pk_valid;
  logic             word_valid;
  logic [31:0]      word;

  assign in_ready = (state != DONE) && (state != ERROR);
  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign error    = (state == ERROR);

  assign take     = in_valid && in_ready;
  assign pk_clear = take && (state == IDLE);
  assign pk_valid = take && (state == DATA);
  assign ww_next  = words_written + IDX_W'(1);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .valid      (pk_valid),
    .din        (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      n_words       <= '0;
      csum          <= '0;
      words_written <= '0;
      mem_we        <= 1'b0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take && in_data == SYNC_BYTE) begin
            state         <= COUNT;
            words_written <= '0;
            csum          <= '0;
          end
        end
        COUNT: begin
          if (take) begin
            n_words <= IDX_W'(in_data);
            if (in_data == 8'd0 || in_data > MAX_N)
              state <= ERROR;
            else
              state <= DATA;
          end
        end
        DATA: begin
          if (take) begin
            csum <= csum ^ in_data;
            if (word_valid) begin
              mem_we        <= 1'b1;
              mem_waddr     <= 32'({words_written, 2'b00});
              mem_wdata     <= word;
              words_written <= ww_next;
              if (ww_next == n_words)
                state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (take)
            state <= (in_data == csum) ? DONE : ERROR;
        end
        DONE, ERROR: begin
          if (clr)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader.
// Directed plan steps plus randomized frames against a frame-level model.
module tb_instr_mem_loader;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        clr;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [7:0]  words_written;

  int vectors = 0;
  int fails = 0;
  bit gaps = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] nominal[$];

  instr_mem_loader #(
    .MEM_WORDS (MW),
    .SYNC_BYTE (8'hA5),
    .IDX_W     (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .clr           (clr),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Every write strobe must match the next write predicted by the model.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_a.size() == 0) begin
        chk("unexpected_we", {31'b0, mem_we}, 32'd0);
      end else begin
        chk("waddr", mem_waddr, exp_a.pop_front());
        chk("wdata", mem_wdata, exp_d.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    while (gaps && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
  endtask

  task automatic check_status(input bit good, input logic [7:0] ww);
    chk("done", {31'b0, done}, {31'b0, good});
    chk("error", {31'b0, error}, {31'b0, !good});
    chk("cpu_hold", {31'b0, cpu_hold}, {31'b0, !good});
    chk("in_ready", {31'b0, in_ready}, 32'd0);
    chk("words_written", 32'(words_written), 32'(ww));
    chk("writes_pending", exp_a.size(), 32'd0);
  endtask

  task automatic load(input logic [7:0] n, input logic [31:0] w[$],
                      input logic [7:0] flip, input int garbage);
    logic [7:0] ck;
    logic [7:0] b;
    bit ok;
    ck = 8'h00;
    ok = (n != 8'd0) && (int'(n) <= MW);
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom_range(0, 255));
      send((b == 8'hA5) ? 8'h11 : b);
    end
    send(8'hA5);
    send(n);
    if (ok) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_a.push_back(32'(i * 4));
        exp_d.push_back(w[i]);
        for (int k = 0; k < 4; k++) begin
          b = w[i][8*k +: 8];
          ck = ck ^ b;
          send(b);
        end
      end
      send(ck ^ flip);
    end
    in_valid = 1'b0;
    check_status(ok && flip == 8'h00, ok ? n : 8'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_done", {31'b0, done}, 32'd0);
    chk("clr_error", {31'b0, error}, 32'd0);
    chk("clr_hold", {31'b0, cpu_hold}, 32'd1);
    chk("clr_ready", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_vals();
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_ww", 32'(words_written), 32'd0);
    chk("rst_hold", {31'b0, cpu_hold}, 32'd1);
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] empty[$];
    int n;
    rst = 1'b1;
    clr = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    nominal = '{32'h00500013, 32'h00100093};
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    chk("hold_after_rst", {31'b0, cpu_hold}, 32'd1);

    load(8'd2, nominal, 8'h00, 0);
    // Byte arriving with clr in DONE must be dropped; a following 00
    // would otherwise be taken as a zero count and flag an error.
    clr = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    clr = 1'b0;
    in_data = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    chk("clr_beats_byte", {31'b0, error}, 32'd0);

    load(8'd2, nominal, 8'h01, 0);
    do_clr();
    load(8'd0, empty, 8'h00, 0);
    do_clr();
    load(8'd9, empty, 8'h00, 0);
    do_clr();

    w = {};
    for (int i = 0; i < MW; i++) w.push_back($urandom());
    load(8'd8, w, 8'h00, 0);
    do_clr();

    load(8'd2, nominal, 8'h00, 2);
    do_clr();
    w = '{32'hA5A5A5A5, 32'h000000A5};
    load(8'd2, w, 8'h00, 0);
    do_clr();

    gaps = 1;
    load(8'd2, nominal, 8'h00, 0);
    gaps = 0;
    do_clr();

    // Reset after six data bytes: only word 0 should have been written.
    send(8'hA5);
    send(8'h02);
    exp_a.push_back(32'h0);
    exp_d.push_back(nominal[0]);
    for (int k = 0; k < 4; k++) send(nominal[0][8*k +: 8]);
    send(nominal[1][7:0]);
    send(nominal[1][15:8]);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pending", exp_a.size(), 32'd0);
    load(8'd2, nominal, 8'h00, 0);
    do_clr();

    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(0, 10);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom());
      gaps = ($urandom_range(0, 1) == 1);
      load(8'(n), w, ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
           $urandom_range(0, 2));
      gaps = 0;
      do_clr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
